lsu_mem_port: RTL

- Load/store memory port. Sits between the execute stage and the load data extender.
- Accepts one load/store request per transaction and drives word-aligned data memory with byte enables and replicated store data.
- For loads, shifts the returned word so the addressed byte or halfword lands at bit 0, then presents it with funct3 as the extender's raw data and opcode.
- Detects misaligned and illegal accesses without touching memory.

---
 rtl/lsu_mem_port_pkg.sv | 21 ++
 rtl/lsu_lane_align.sv | 52 +++++
 rtl/lsu_mem_port.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the load/store memory port: RV32 load/store funct3 codes
// and the transaction FSM state encoding.
package lsu_mem_port_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: byte enables, store data replication, load data
// right-shift, and misaligned/illegal access detection.
module lsu_lane_align
  import lsu_mem_port_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_rd_off,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic w_illegal;
  logic w_misaligned;

  always_comb begin
    w_illegal = 1'b1;
    unique case (i_funct3)
      F3_LB, F3_LH, F3_LW: w_illegal = 1'b0;
      F3_LBU, F3_LHU:      w_illegal = i_we;
      default:             w_illegal = 1'b1;
    endcase

    w_misaligned = ((i_funct3[1:0] == 2'b01) && i_off[0]) ||
                   ((i_funct3[1:0] == 2'b10) && (i_off != 2'b00));
    o_err = w_illegal | w_misaligned;

    unique case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = 4'b0011 << i_off;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase

    // Upper bits keep whatever was shifted in; the downstream extender masks them.
    o_rdata = i_rdata >> {i_rd_off, 3'b000};
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store memory port between execute and the load extender. Registers every
// output and runs one transaction at a time through IDLE/REQ/WAIT/RESP.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic [2:0]        o_resp_funct3,
  output logic              o_resp_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_e            r_state, w_state_nxt;
  logic              r_we, w_we_nxt;
  logic [2:0]        r_funct3, w_funct3_nxt;
  logic [1:0]        r_off, w_off_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [3:0]        r_mem_be, w_mem_be_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_resp_valid, w_resp_valid_nxt;
  logic [DATA_W-1:0] r_resp_rdata, w_resp_rdata_nxt;
  logic [2:0]        r_resp_funct3, w_resp_funct3_nxt;
  logic              r_resp_err, w_resp_err_nxt;

  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata_rep;
  logic [DATA_W-1:0] w_rdata_shift;
  logic              w_err;

  lsu_lane_align u_lane_align (
    .i_we     (i_req_we),
    .i_funct3 (i_req_funct3),
    .i_off    (i_req_addr[1:0]),
    .i_wdata  (i_req_wdata),
    .i_rd_off (r_off),
    .i_rdata  (i_mem_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata_rep),
    .o_rdata  (w_rdata_shift),
    .o_err    (w_err)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_we_nxt          = r_we;
    w_funct3_nxt      = r_funct3;
    w_off_nxt         = r_off;
    w_mem_req_nxt     = r_mem_req;
    w_mem_we_nxt      = r_mem_we;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_be_nxt      = r_mem_be;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_resp_valid_nxt  = 1'b0;
    w_resp_rdata_nxt  = r_resp_rdata;
    w_resp_funct3_nxt = r_resp_funct3;
    w_resp_err_nxt    = r_resp_err;

    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_we_nxt     = i_req_we;
          w_funct3_nxt = i_req_funct3;
          w_off_nxt    = i_req_addr[1:0];
          if (w_err) begin
            // Rejected accesses complete immediately without touching memory.
            w_state_nxt       = StResp;
            w_resp_valid_nxt  = 1'b1;
            w_resp_err_nxt    = 1'b1;
            w_resp_rdata_nxt  = '0;
            w_resp_funct3_nxt = i_req_funct3;
          end else begin
            w_state_nxt     = StReq;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = i_req_we;
            w_mem_addr_nxt  = {i_req_addr[ADDR_W-1:2], 2'b00};
            w_mem_be_nxt    = w_be;
            w_mem_wdata_nxt = w_wdata_rep;
          end
        end
      end
      StReq: begin
        if (i_mem_gnt) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = StWait;
        end
      end
      StWait: begin
        if (i_mem_rvalid) begin
          w_state_nxt       = StResp;
          w_resp_valid_nxt  = 1'b1;
          w_resp_err_nxt    = 1'b0;
          w_resp_funct3_nxt = r_funct3;
          w_resp_rdata_nxt  = r_we ? '0 : w_rdata_shift;
        end
      end
      StResp: begin
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_we          <= 1'b0;
      r_funct3      <= '0;
      r_off         <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_be      <= '0;
      r_mem_wdata   <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= '0;
      r_resp_funct3 <= '0;
      r_resp_err    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_we          <= w_we_nxt;
      r_funct3      <= w_funct3_nxt;
      r_off         <= w_off_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_be      <= w_mem_be_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_resp_valid  <= w_resp_valid_nxt;
      r_resp_rdata  <= w_resp_rdata_nxt;
      r_resp_funct3 <= w_resp_funct3_nxt;
      r_resp_err    <= w_resp_err_nxt;
    end
  end

  assign o_req_ready   = (r_state == StIdle);
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_rdata  = r_resp_rdata;
  assign o_resp_funct3 = r_resp_funct3;
  assign o_resp_err    = r_resp_err;
  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_be      = r_mem_be;
  assign o_mem_wdata   = r_mem_wdata;

endmodule
